// File: rtl/scr1_dmi_arb_pkg.sv
// Shared DMI arbiter types: arbiter state, transaction owner and the DMI command layout.
// Default widths follow the codebase DMI address/data widths.
package scr1_dmi_arb_pkg;

   localparam int SCR1_DBG_DMI_ADDR_WIDTH = 7;
   localparam int SCR1_DBG_DMI_DATA_WIDTH = 32;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_D = 1'b0,
      OWN_S = 1'b1
   } arb_owner_e;

   typedef struct packed {
      logic                               wr;
      logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] addr;
      logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] wdata;
   } dmi_cmd_t;

   // Round-robin pick: D wins when it is the only candidate or when S was served last.
   function automatic logic arb_pick_d(input logic cand_d, input logic cand_s,
                                       input arb_owner_e last);
      return cand_d & (~cand_s | (last == OWN_S));
   endfunction

endpackage

// File: rtl/scr1_dmi_arb_pend.sv
// Single-entry holding buffer for a DTM command; flags a request that cannot be accepted.
module scr1_dmi_arb_pend
   import scr1_dmi_arb_pkg::*;
#(
   parameter int AW = SCR1_DBG_DMI_ADDR_WIDTH,
   parameter int DW = SCR1_DBG_DMI_DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          clr,
   input  logic          inflight,
   input  logic          ld_wr,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          full,
   output logic          wr,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdata,
   output logic          overrun
);

   logic          full_r;
   logic          wr_r;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] wdata_r;

   // A pulse is lost if the slot is occupied or the DTM already owns the DM.
   assign overrun = load & (full_r | inflight);

   // Holds the command until the arbiter grants D.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_r  <= 1'b0;
         wr_r    <= 1'b0;
         addr_r  <= {AW{1'b0}};
         wdata_r <= {DW{1'b0}};
      end else if (clr) begin
         full_r <= 1'b0;
      end else if (load & ~overrun) begin
         full_r  <= 1'b1;
         wr_r    <= ld_wr;
         addr_r  <= ld_addr;
         wdata_r <= ld_wdata;
      end
   end

   assign full  = full_r;
   assign wr    = wr_r;
   assign addr  = addr_r;
   assign wdata = wdata_r;

endmodule

// File: rtl/scr1_dmi_arb.sv
// DMI arbiter between the JTAG DTM (D) and a system debug port (S) in front of the Debug Module.
// Define SCR1_DMI_ARB_TIMEOUT_EN to abort DM transactions that see no response.
module scr1_dmi_arb
   import scr1_dmi_arb_pkg::*;
#(
   parameter int AW             = SCR1_DBG_DMI_ADDR_WIDTH,
   parameter int DW             = SCR1_DBG_DMI_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          dtm_req,
   input  logic          dtm_wr,
   input  logic [AW-1:0] dtm_addr,
   input  logic [DW-1:0] dtm_wdata,
   output logic          dtm_resp,
   output logic [DW-1:0] dtm_rdata,
   output logic          dtm_busy,
   output logic          dtm_err,
   input  logic          dtm_err_clr,
   input  logic          sys_req,
   input  logic          sys_wr,
   input  logic [AW-1:0] sys_addr,
   input  logic [DW-1:0] sys_wdata,
   output logic          sys_resp,
   output logic [DW-1:0] sys_rdata,
   output logic          sys_err,
   output logic          dm_req,
   output logic          dm_wr,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_wdata,
   input  logic          dm_resp,
   input  logic [DW-1:0] dm_rdata
);

   arb_state_e    state_r;
   arb_owner_e    owner_r;
   arb_owner_e    last_r;
   logic          dm_req_r;
   logic          dm_wr_r;
   logic [AW-1:0] dm_addr_r;
   logic [DW-1:0] dm_wdata_r;
   logic          dtm_resp_r;
   logic [DW-1:0] dtm_rdata_r;
   logic          dtm_err_r;

   logic          pend_full_s;
   logic          pend_wr_s;
   logic [AW-1:0] pend_addr_s;
   logic [DW-1:0] pend_wdata_s;
   logic          overrun_s;
   logic          busy_s;
   logic          own_d_s;
   logic          own_s_s;
   logic          pick_d_s;
   logic          gnt_d_s;
   logic          gnt_s_s;
   logic          tmo_s;
   logic          done_s;
   logic          err_set_s;

   assign busy_s    = (state_r == ARB_BUSY);
   assign own_d_s   = busy_s & (owner_r == OWN_D);
   assign own_s_s   = busy_s & (owner_r == OWN_S);
   assign pick_d_s  = arb_pick_d(pend_full_s, sys_req, last_r);
   assign gnt_d_s   = ~busy_s & pick_d_s;
   assign gnt_s_s   = ~busy_s & sys_req & ~pick_d_s;
   assign done_s    = busy_s & (dm_resp | tmo_s);
   assign err_set_s = overrun_s | (own_d_s & tmo_s);

   scr1_dmi_arb_pend #(.AW(AW), .DW(DW)) u_pend (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dtm_req),
      .clr      (gnt_d_s),
      .inflight (own_d_s),
      .ld_wr    (dtm_wr),
      .ld_addr  (dtm_addr),
      .ld_wdata (dtm_wdata),
      .full     (pend_full_s),
      .wr       (pend_wr_s),
      .addr     (pend_addr_s),
      .wdata    (pend_wdata_s),
      .overrun  (overrun_s)
   );

`ifdef SCR1_DMI_ARB_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES) + 1 > 8) ? $clog2(TIMEOUT_CYCLES) + 1 : 8;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] tmo_cnt_r;

   // Counts BUSY cycles that pass without a DM response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= {CW{1'b0}};
      end else if (gnt_d_s | gnt_s_s) begin
         tmo_cnt_r <= {CW{1'b0}};
      end else if (busy_s & ~dm_resp) begin
         tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
      end
   end

   // A response arriving in the final cycle takes precedence over the abort.
   assign tmo_s   = busy_s & ~dm_resp & (tmo_cnt_r == CNT_LAST);
   assign sys_err = own_s_s & tmo_s;
`else
   assign tmo_s   = 1'b0;
   assign sys_err = 1'b0;
`endif

   assign sys_resp  = own_s_s & (dm_resp | tmo_s);
   assign sys_rdata = (own_s_s & dm_resp) ? dm_rdata : {DW{1'b0}};
   assign dtm_busy  = pend_full_s | own_d_s;

   // Arbiter FSM: grant in IDLE, hold the DM command in BUSY, route the D response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ARB_IDLE;
         owner_r     <= OWN_D;
         last_r      <= OWN_S;
         dm_req_r    <= 1'b0;
         dm_wr_r     <= 1'b0;
         dm_addr_r   <= {AW{1'b0}};
         dm_wdata_r  <= {DW{1'b0}};
         dtm_resp_r  <= 1'b0;
         dtm_rdata_r <= {DW{1'b0}};
         dtm_err_r   <= 1'b0;
      end else begin
         dtm_resp_r <= 1'b0;
         if (err_set_s) begin
            dtm_err_r <= 1'b1;
         end else if (dtm_err_clr) begin
            dtm_err_r <= 1'b0;
         end
         case (state_r)
            ARB_IDLE: begin
               if (gnt_d_s) begin
                  state_r    <= ARB_BUSY;
                  owner_r    <= OWN_D;
                  last_r     <= OWN_D;
                  dm_req_r   <= 1'b1;
                  dm_wr_r    <= pend_wr_s;
                  dm_addr_r  <= pend_addr_s;
                  dm_wdata_r <= pend_wdata_s;
               end else if (gnt_s_s) begin
                  state_r    <= ARB_BUSY;
                  owner_r    <= OWN_S;
                  last_r     <= OWN_S;
                  dm_req_r   <= 1'b1;
                  dm_wr_r    <= sys_wr;
                  dm_addr_r  <= sys_addr;
                  dm_wdata_r <= sys_wdata;
               end
            end
            ARB_BUSY: begin
               if (done_s) begin
                  state_r  <= ARB_IDLE;
                  dm_req_r <= 1'b0;
                  if (owner_r == OWN_D) begin
                     dtm_resp_r <= 1'b1;
                     if (dm_resp & ~dm_wr_r) begin
                        dtm_rdata_r <= dm_rdata;
                     end
                  end
               end
            end
            default: begin
               state_r  <= ARB_IDLE;
               dm_req_r <= 1'b0;
            end
         endcase
      end
   end

   assign dm_req    = dm_req_r;
   assign dm_wr     = dm_wr_r;
   assign dm_addr   = dm_addr_r;
   assign dm_wdata  = dm_wdata_r;
   assign dtm_resp  = dtm_resp_r;
   assign dtm_rdata = dtm_rdata_r;
   assign dtm_err   = dtm_err_r;

endmodule

// File: tb/tb_scr1_dmi_arb.sv
// Directed self-checking bench for scr1_dmi_arb; the timeout case runs when SCR1_DMI_ARB_TIMEOUT_EN is defined.
module tb_scr1_dmi_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dtm_req, dtm_wr, dtm_resp, dtm_busy, dtm_err, dtm_err_clr;
   logic [6:0]  dtm_addr;
   logic [31:0] dtm_wdata, dtm_rdata;
   logic        sys_req, sys_wr, sys_resp, sys_err;
   logic [6:0]  sys_addr;
   logic [31:0] sys_wdata, sys_rdata;
   logic        dm_req, dm_wr, dm_resp;
   logic [6:0]  dm_addr;
   logic [31:0] dm_wdata, dm_rdata;

   int total = 0;
   int bad   = 0;

   scr1_dmi_arb #(.AW(7), .DW(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .dtm_req(dtm_req), .dtm_wr(dtm_wr), .dtm_addr(dtm_addr), .dtm_wdata(dtm_wdata),
      .dtm_resp(dtm_resp), .dtm_rdata(dtm_rdata), .dtm_busy(dtm_busy), .dtm_err(dtm_err),
      .dtm_err_clr(dtm_err_clr),
      .sys_req(sys_req), .sys_wr(sys_wr), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
      .sys_resp(sys_resp), .sys_rdata(sys_rdata), .sys_err(sys_err),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_resp(dm_resp), .dm_rdata(dm_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      dtm_req = 1'b0; dtm_wr = 1'b0; dtm_addr = 7'h0; dtm_wdata = 32'h0; dtm_err_clr = 1'b0;
      sys_req = 1'b0; sys_wr = 1'b0; sys_addr = 7'h0; sys_wdata = 32'h0;
      dm_resp = 1'b0; dm_rdata = 32'h0;
      repeat (2) nxt();
      rst_n = 1'b1;
   endtask

   initial begin
      int  grants;
      int  hi;
      logic prev;
      logic exp_d;

      // reset values
      do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_dm_req",   32'(dm_req),   32'h0);
      chk("rst_dtm_resp", 32'(dtm_resp), 32'h0);
      chk("rst_dtm_busy", 32'(dtm_busy), 32'h0);
      chk("rst_dtm_err",  32'(dtm_err),  32'h0);
      chk("rst_sys_resp", 32'(sys_resp), 32'h0);
      chk("rst_dtm_rd",   dtm_rdata,     32'h0);
      do_reset();

      // 1: S read, DM answers in the third dm_req cycle
      sys_req = 1'b1; sys_wr = 1'b0; sys_addr = 7'h10; sys_wdata = 32'h0;
      smp();
      chk("t1_req_c0", 32'(dm_req), 32'h0);
      nxt(); smp();
      chk("t1_req_c1", 32'(dm_req), 32'h1);
      chk("t1_addr",   32'(dm_addr), 32'h10);
      chk("t1_wr",     32'(dm_wr), 32'h0);
      nxt(); smp();
      chk("t1_req_c2", 32'(dm_req), 32'h1);
      chk("t1_noresp", 32'(sys_resp), 32'h0);
      nxt(); dm_resp = 1'b1; dm_rdata = 32'hDEADBEEF; smp();
      chk("t1_req_c3", 32'(dm_req), 32'h1);
      chk("t1_resp",   32'(sys_resp), 32'h1);
      chk("t1_rdata",  sys_rdata, 32'hDEADBEEF);
      chk("t1_err",    32'(sys_err), 32'h0);
      nxt(); dm_resp = 1'b0; sys_req = 1'b0; smp();
      chk("t1_req_c4", 32'(dm_req), 32'h0);
      chk("t1_rdz",    sys_rdata, 32'h0);

      // 2: DTM write and S read meet in IDLE; D wins the first tie
      do_reset();
      dtm_req = 1'b1; dtm_wr = 1'b1; dtm_addr = 7'h11; dtm_wdata = 32'h1;
      nxt(); dtm_req = 1'b0; sys_req = 1'b1; sys_addr = 7'h20; smp();
      chk("t2_busy_pend", 32'(dtm_busy), 32'h1);
      chk("t2_req_c1",    32'(dm_req), 32'h0);
      nxt(); smp();
      chk("t2_d_req",   32'(dm_req), 32'h1);
      chk("t2_d_addr",  32'(dm_addr), 32'h11);
      chk("t2_d_wr",    32'(dm_wr), 32'h1);
      chk("t2_d_wdata", dm_wdata, 32'h1);
      nxt(); dm_resp = 1'b1; dm_rdata = 32'h55; smp();
      chk("t2_no_sys",  32'(sys_resp), 32'h0);
      nxt(); dm_resp = 1'b0; smp();
      chk("t2_gap",     32'(dm_req), 32'h0);
      chk("t2_dtm_rsp", 32'(dtm_resp), 32'h1);
      chk("t2_wr_keep", dtm_rdata, 32'h0);
      chk("t2_idle_bz", 32'(dtm_busy), 32'h0);
      nxt(); smp();
      chk("t2_s_req",   32'(dm_req), 32'h1);
      chk("t2_s_addr",  32'(dm_addr), 32'h20);
      chk("t2_rsp_1c",  32'(dtm_resp), 32'h0);
      nxt(); dm_resp = 1'b1; dm_rdata = 32'h1234; smp();
      chk("t2_s_rdata", sys_rdata, 32'h1234);
      nxt(); dm_resp = 1'b0; sys_req = 1'b0; smp();
      chk("t2_end", 32'(dm_req), 32'h0);

      // 3: overrun while S is in flight, then set beats clear
      sys_req = 1'b1; sys_wr = 1'b0; sys_addr = 7'h30;
      nxt(); dtm_req = 1'b1; dtm_wr = 1'b0; dtm_addr = 7'h12;
      nxt(); dtm_req = 1'b0; smp();
      chk("t3_busy", 32'(dtm_busy), 32'h1);
      chk("t3_err0", 32'(dtm_err), 32'h0);
      nxt(); dtm_req = 1'b1; dtm_addr = 7'h13;
      nxt(); dtm_req = 1'b0; dm_resp = 1'b1; dm_rdata = 32'h7; smp();
      chk("t3_err1",  32'(dtm_err), 32'h1);
      chk("t3_saddr", 32'(dm_addr), 32'h30);
      nxt(); dm_resp = 1'b0; sys_req = 1'b0; smp();
      chk("t3_gap", 32'(dm_req), 32'h0);
      nxt(); dtm_req = 1'b1; dtm_err_clr = 1'b1; smp();
      chk("t3_d_addr", 32'(dm_addr), 32'h12);
      nxt(); dtm_req = 1'b0; dtm_err_clr = 1'b0; dm_resp = 1'b1; dm_rdata = 32'hCAFE0001; smp();
      chk("t3_setwins", 32'(dtm_err), 32'h1);
      nxt(); dm_resp = 1'b0; dtm_err_clr = 1'b1; smp();
      chk("t3_dtm_rsp", 32'(dtm_resp), 32'h1);
      chk("t3_rdata",   dtm_rdata, 32'hCAFE0001);
      chk("t3_empty",   32'(dtm_busy), 32'h0);
      nxt(); dtm_err_clr = 1'b0; smp();
      chk("t3_clr",     32'(dtm_err), 32'h0);
      chk("t3_one_d",   32'(dm_req), 32'h0);

      // 4: reset while D owns the DM
      do_reset();
      dtm_req = 1'b1; dtm_wr = 1'b0; dtm_addr = 7'h14;
      nxt(); dtm_req = 1'b0;
      nxt(); smp();
      chk("t4_busy_req", 32'(dm_req), 32'h1);
      dm_resp = 1'b1; dm_rdata = 32'h99;
      rst_n = 1'b0;
      #1;
      chk("t4_async", 32'(dm_req), 32'h0);
      nxt(); rst_n = 1'b1; dm_resp = 1'b0; smp();
      chk("t4_no_resp", 32'(dtm_resp), 32'h0);
      chk("t4_rdata",   dtm_rdata, 32'h0);
      chk("t4_busy",    32'(dtm_busy), 32'h0);
      nxt(); smp();
      chk("t4_no_req",  32'(dm_req), 32'h0);

      // 5: continuous S traffic with DTM refills alternates D/S
      do_reset();
      dtm_req = 1'b1; dtm_wr = 1'b0; dtm_addr = 7'h41;
      nxt(); dtm_req = 1'b0; sys_req = 1'b1; sys_wr = 1'b0; sys_addr = 7'h20;
      exp_d = 1'b1; grants = 0; hi = 0; prev = 1'b0;
      for (int c = 0; c < 80 && grants < 8; c++) begin
         nxt();
         dtm_req = 1'b0; dm_resp = 1'b0;
         if (dm_req && !prev) begin
            chk("t5_alt", 32'(dm_addr == 7'h41), 32'(exp_d));
            exp_d = ~exp_d;
            grants++;
         end
         prev = dm_req;
         hi = dm_req ? hi + 1 : 0;
         if (hi == 2) begin
            dm_resp = 1'b1; dm_rdata = 32'h0;
         end
         if (!dtm_busy && dm_req && dm_addr == 7'h20) dtm_req = 1'b1;
      end
      chk("t5_grants", 32'(grants), 32'd8);
      sys_req = 1'b0; dm_resp = 1'b0; dtm_req = 1'b0;

`ifdef SCR1_DMI_ARB_TIMEOUT_EN
      // 6: DM silent, then DM answering in the last allowed cycle
      do_reset();
      sys_req = 1'b1; sys_addr = 7'h22; dm_rdata = 32'hFFFFFFFF;
      hi = 0;
      for (int c = 0; c < 4; c++) begin
         nxt(); smp();
         if (dm_req) hi++;
      end
      chk("t6_resp",  32'(sys_resp), 32'h1);
      chk("t6_err",   32'(sys_err), 32'h1);
      chk("t6_rdata", sys_rdata, 32'h0);
      nxt(); sys_req = 1'b0; smp();
      chk("t6_drop",  32'(dm_req), 32'h0);
      chk("t6_width", 32'(hi), 32'd4);
      sys_req = 1'b1;
      for (int c = 0; c < 3; c++) nxt();
      nxt(); dm_resp = 1'b1; dm_rdata = 32'hABCD; smp();
      chk("t6b_resp",  32'(sys_resp), 32'h1);
      chk("t6b_err",   32'(sys_err), 32'h0);
      chk("t6b_rdata", sys_rdata, 32'hABCD);
      nxt(); dm_resp = 1'b0; sys_req = 1'b0; smp();
      chk("t6b_drop",  32'(dm_req), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
